beat_playback_reader: RTL

- Read side of the beat recording RAM; the recording path fills it while the mode FSM is in record mode.
- When the mode FSM requests playback, this block walks RAM addresses 0..length-1, one slot per beat period.
- It presents each stored note code to the buzzer/note-decoder path.
- It supports one-shot and looped playback, and reports completion back to the mode FSM.

---
 rtl/beat_playback_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/beat_playback_reader.sv
// beat_playback_reader: read side of the beat recording RAM.
// Walks slots 0..len-1 one beat period each and presents the stored note
// codes; supports one-shot and looped playback with a done pulse at the end.
module beat_playback_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 4,
    parameter int TICK_DIV   = 12500000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  play,
    input  logic                  loop_en,
    input  logic [ADDR_WIDTH:0]   rec_length,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] note_out,
    output logic                  note_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [ADDR_WIDTH:0]     len, len_nx;
    logic [ADDR_WIDTH-1:0]   addr_nx;
    logic [DATA_WIDTH-1:0]   note_nx;
    logic                    valid_nx;
    logic                    done_nx;
    logic                    last_slot;

    // Current address is the final slot of the latched length.
    assign last_slot = ({1'b0, ram_addr} == (len - LEN_ONE));

    // Busy covers every state that is actively walking slots.
    assign busy = (state == S_FETCH) || (state == S_LATCH) || (state == S_HOLD);

    // State and datapath registers; reset aborts playback without a done pulse.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            len        <= '0;
            ram_addr   <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            len        <= len_nx;
            ram_addr   <= addr_nx;
            note_out   <= note_nx;
            note_valid <= valid_nx;
            done       <= done_nx;
        end
    end

    // Next-state and next-output logic; abort takes priority over slot end.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        addr_nx  = ram_addr;
        note_nx  = note_out;
        valid_nx = note_valid;
        done_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (play && (rec_length != '0)) begin
                    len_nx   = (rec_length > FULL_LEN) ? FULL_LEN : rec_length;
                    addr_nx  = '0;
                    cnt_nx   = '0;
                    state_nx = S_FETCH;
                end
            end

            S_FETCH, S_LATCH, S_HOLD: begin
                if (!play) begin
                    state_nx = S_IDLE;
                    note_nx  = '0;
                    valid_nx = 1'b0;
                    addr_nx  = '0;
                    cnt_nx   = '0;
                end else if (state == S_FETCH) begin
                    cnt_nx   = CNT_W'(1);
                    state_nx = S_LATCH;
                end else if (state == S_LATCH) begin
                    note_nx  = ram_q;
                    valid_nx = 1'b1;
                    cnt_nx   = CNT_W'(2);
                    state_nx = S_HOLD;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx = '0;
                    if (!last_slot) begin
                        addr_nx  = ram_addr + 1'b1;
                        state_nx = S_FETCH;
                    end else if (loop_en) begin
                        addr_nx  = '0;
                        state_nx = S_FETCH;
                    end else begin
                        note_nx  = '0;
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            S_DONE: begin
                if (!play) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
